// File: rtl/stopwatch_ctrl_if.sv
// Bundle of the controller's run/pause/clear strobes, digit feedback and
// digit-counter control outputs. master = environment side, slave = controller.
interface stopwatch_ctrl_if;
   logic       start_stop;
   logic       clear;
   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic [3:0] x_out;
   logic       cnt_clr_n;
   logic       running;
   logic       ovf;

   modport master (
      output start_stop, clear, d0, d1, d2, d3,
      input  x_out, cnt_clr_n, running, ovf
   );

   modport slave (
      input  start_stop, clear, d0, d1, d2, d3,
      output x_out, cnt_clr_n, running, ovf
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for a 4-digit BCD stopwatch. Divides clk down to
// the count rate, drives the digit enables through a decimal carry chain and
// freezes the display at 9999 on overflow.
module stopwatch_ctrl #(
   parameter int PRESCALE = 4
) (
   input  logic               clk,
   input  logic               reset,
   stopwatch_ctrl_if.slave    bus
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          clr_n_q, clr_n_d;

   logic tick;
   logic c0, c1, c2, c3;
   logic all9;

   assign tick = (state_q == RUN) && (pre_q == PRE_MAX);
   assign c0   = (bus.d0 == 4'd9);
   assign c1   = (bus.d1 == 4'd9);
   assign c2   = (bus.d2 == 4'd9);
   assign c3   = (bus.d3 == 4'd9);
   assign all9 = c0 & c1 & c2 & c3;

   // State, prescaler and registered counter clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pre_q   <= '0;
         clr_n_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         clr_n_q <= clr_n_d;
      end
   end

   // Next state; clear wins over start_stop everywhere. The prescaler advances
   // on every RUN cycle, including the one that pauses, so the sub-tick phase
   // survives pause/resume.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      clr_n_d = 1'b1;
      if (bus.clear) begin
         state_d = IDLE;
         pre_d   = '0;
         clr_n_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_stop) begin
                  state_d = RUN;
                  pre_d   = '0;
               end
            end
            RUN: begin
               pre_d = tick ? '0 : pre_q + PW'(1);
               if (tick && all9)
                  state_d = OVF;
               else if (bus.start_stop)
                  state_d = PAUSE;
            end
            PAUSE: begin
               if (bus.start_stop)
                  state_d = RUN;
            end
            OVF: begin
               state_d = OVF;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Decimal carry chain; suppressed entirely on the 9999 -> overflow tick so
   // the display holds at 9999.
   always_comb begin
      bus.x_out = 4'b0000;
      if (tick && !all9)
         bus.x_out = {c0 & c1 & c2, c0 & c1, c0, 1'b1};
   end

   assign bus.cnt_clr_n = clr_n_q;
   assign bus.running   = (state_q == RUN);
   assign bus.ovf       = (state_q == OVF);

endmodule
